pll_lock_rst_gen: RTL and testbench

- Sits directly upstream of the per-domain LED blinker instances, between the PLL `locked` output and their reset inputs.
- Synchronises the asynchronous PLL lock flag into its clock domain.
- Qualifies lock: requires lock to be stable for a programmable number of cycles before releasing an active-low reset to downstream logic.
- On loss of lock, re-asserts that reset for a guaranteed minimum width, then requalifies before releasing again.

---
 rtl/pll_rst_pkg.sv | 13 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_rst_gen.sv | 109 ++++++++++
 tb/tb_pll_lock_rst_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock qualifier / reset generator.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_MIN  = 2'd3
  } pll_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width double-flop synchroniser with synchronous clear.
module sync_2ff
  import pll_rst_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk) begin
    if (clr) pipe <= '0;
    else     pipe <= {pipe[SYNC_STAGES-2:0], d};
  end

  assign q = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_rst_gen.sv
// Qualifies the PLL lock flag and drives a registered active-low reset downstream.
// Optional lost-lock event counter enabled by defining PLL_LOST_CNT_EN.
module pll_lock_rst_gen
  import pll_rst_pkg::*;
#(
  parameter int HOLD_CYCLES    = 1024,
  parameter int MIN_RST_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             rst_n_out,
  output logic             release_pulse
`ifdef PLL_LOST_CNT_EN
  , output logic [CNT_W-1:0] lost_cnt
`endif
);

  localparam int CMAX = (HOLD_CYCLES > MIN_RST_CYCLES) ? HOLD_CYCLES : MIN_RST_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  pll_state_e  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        lock_s;
  logic        lost_inc;
  logic        rst_n_d1;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Entry into HOLD/MIN loads 1 so the entry edge counts as the first cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lost_inc = 1'b0;
    case (state)
      S_WAIT: begin
        cnt_n = '0;
        if (lock_s) begin
          state_n = S_HOLD;
          cnt_n   = CW'(1);
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else if (cnt == CW'(HOLD_CYCLES)) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          state_n  = S_MIN;
          cnt_n    = CW'(1);
          lost_inc = 1'b1;
        end
      end
      S_MIN: begin
        if (cnt == CW'(MIN_RST_CYCLES)) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      cnt       <= '0;
      rst_n_out <= 1'b0;
      rst_n_d1  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rst_n_out <= (state_n == S_RUN);
      rst_n_d1  <= rst_n_out;
    end
  end

  assign release_pulse = rst_n_out & ~rst_n_d1;

`ifdef PLL_LOST_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           lost_cnt <= '0;
    else if (lost_inc && ~&lost_cnt)   lost_cnt <= lost_cnt + CNT_W'(1);
  end
`else
  logic unused_lost_inc;
  assign unused_lost_inc = lost_inc;
`endif

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Scoreboard bench for pll_lock_rst_gen; honours PLL_LOST_CNT_EN when defined.
module tb_pll_lock_rst_gen;

  localparam int H  = 8;
  localparam int M  = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic rst_n_out, release_pulse;
`ifdef PLL_LOST_CNT_EN
  logic [CW-1:0] lost_cnt;
`endif

  always #5 clk = ~clk;

  pll_lock_rst_gen #(.HOLD_CYCLES(H), .MIN_RST_CYCLES(M), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .rst_n_out     (rst_n_out),
    .release_pulse (release_pulse)
`ifdef PLL_LOST_CNT_EN
    , .lost_cnt    (lost_cnt)
`endif
  );

  typedef struct {
    logic rn;
    logic rp;
    int   lc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: lock history as a 2-deep delay, qualification and the
  // minimum-reset window tracked as edge timestamps.
  int   n = 0;
  bit   h1, h2, running, prev_run;
  int   min_end = -1;
  int   qual_start = -1;
  int   lost = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   ls;
    n++;
    if (rst) begin
      h1 = 0; h2 = 0; running = 0;
      min_end = -1; qual_start = -1; lost = 0;
    end else begin
      ls = h2; h2 = h1; h1 = pll_locked;
      if (running) begin
        if (!ls) begin
          running = 0;
          min_end = n + M;
          if (lost < (1 << CW) - 1) lost++;
        end
      end else if (n <= min_end) begin
        qual_start = -1;
      end else if (!ls) begin
        qual_start = -1;
      end else if (qual_start < 0) begin
        qual_start = n;
      end else if (n - qual_start == H) begin
        running = 1;
        qual_start = -1;
      end
    end
    e.rn = running;
    e.rp = running && !prev_run;
    e.lc = lost;
    prev_run = running;
    q.push_back(e);
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", name, n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty edge=%0d got=0 exp=1", n);
    end else begin
      e = q.pop_front();
      check("rst_n_out", int'(rst_n_out), int'(e.rn));
      check("release_pulse", int'(release_pulse), int'(e.rp));
`ifdef PLL_LOST_CNT_EN
      check("lost_cnt", int'(lost_cnt), e.lc);
`endif
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drop(input int low_len, input int after);
    pll_locked = 1'b0; idle(low_len);
    pll_locked = 1'b1; idle(after);
  endtask

  initial begin
    // basic release
    rst = 1'b1; pll_locked = 1'b0; idle(4);
    rst = 1'b0; pll_locked = 1'b1; idle(25);
    // lock loss and requalification
    drop(2, 40);
    // saturation: four more losses
    for (int i = 0; i < 4; i++) drop(2, 40);
    // unstable lock during qualification
    rst = 1'b1; pll_locked = 1'b0; idle(3);
    rst = 1'b0; pll_locked = 1'b1; idle(5);
    drop(1, 25);
    // reset during RUN
    rst = 1'b1; idle(1); rst = 1'b0; idle(20);
    // reset during MIN
    pll_locked = 1'b0; idle(5);
    rst = 1'b1; idle(1); rst = 1'b0; pll_locked = 1'b1; idle(20);
    // lock return inside the minimum-reset window is ignored
    drop(3, 50);
    // randomized segments
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0;
      end
      pll_locked = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      else                           idle($urandom_range(5, 35));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
